uart_word_arbiter: RTL and testbench
====================================

# uart_word_arbiter

Round-robin arbiter that shares the single 17-bit UART word sender (`uart_wrapper`) between `NUM_REQ` requesters. It sits directly in front of the wrapper and takes one word at a time from the next requester in round-robin order. For each word it issues a one-cycle trigger, then tracks the wrapper's busy signal through the whole 3-byte frame before it accepts another word. A watchdog detects a wrapper that never acknowledges a trigger.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_WIDTH`, default 17: word width; matches the wrapper's `data_in`.
- `ACK_TIMEOUT`, default 8: cycles allowed, after trigger, for the wrapper's busy to rise.

Ports:
- `clk_in`  input  1  system clock; the block uses this one clock only.
- `rst_n_in`  input  1  reset, asynchronous, active-low.
- `req_valid_in`  input  NUM_REQ  per-requester word pending. The requester holds it, and the data, until its ack pulse.
- `req_data_in`  input  NUM_REQ*DATA_WIDTH  flattened words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ack_out`  output  NUM_REQ  one-cycle, one-hot pulse: word captured.
- `uart_data_out`  output  DATA_WIDTH  word to the wrapper's `data_in`.
- `uart_trigger_out`  output  1  one-cycle pulse to the wrapper's `trigger_in`.
- `uart_busy_in`  input  1  the wrapper's `busy_out`.
- `grant_out`  output  NUM_REQ  one-hot owner of the current transfer; 0 when idle.
- `active_out`  output  1  high whenever the state is not IDLE.
- `timeout_err_out`  output  1  sticky watchdog flag; cleared only by reset.

## Operation
- **States:** IDLE, WAIT_BUSY, WAIT_DONE.
- **IDLE → WAIT_BUSY:** the transition occurs when at least one `req_valid_in` bit is set and `uart_busy_in` = 0. On that edge the block:
  - selects the winner;
  - captures its word into `uart_data_out`;
  - sets `grant_out` to the winner's one-hot;
  - pulses `uart_trigger_out` and `req_ack_out[winner]`;
  - updates `last_ptr` to the winner;
  - clears the watchdog counter.
- **Winner selection:** the first set valid bit at or after `last_ptr`+1, searching upward with modulo-`NUM_REQ` wrap.
- **Busy high in IDLE:** the block issues nothing and waits. This covers a wrapper left busy after a reset of this block.
- **WAIT_BUSY:**
  - `uart_busy_in` = 1 → WAIT_DONE.
  - Otherwise the watchdog counter increments each cycle.
  - Counter reaches `ACK_TIMEOUT` → set `timeout_err_out`, clear `grant_out`, go to IDLE. The word is dropped; the requester has already been acked, and the block does not retry.
- **WAIT_DONE:** `uart_busy_in` = 0 → clear `grant_out`, go to IDLE.
- **Held-word rule:** requesters deassert valid or present new data after the ack. A valid still set when the block returns to IDLE is treated as a new word.
- `uart_data_out` holds its value until the next capture.
- `last_ptr` is `ceil(log2(NUM_REQ))` bits wide and holds values 0..NUM_REQ-1 only.

## Timing
- **Reset values** (asynchronous, immediate on `rst_n_in` low):
  - `req_ack_out`, `uart_trigger_out`, `grant_out`, `active_out`, `timeout_err_out`, `uart_data_out` = 0;
  - state = IDLE;
  - `last_ptr` = NUM_REQ-1, so requester 0 has first priority.
- **Normal sequence:**
  - Cycle 0: IDLE, valid seen.
  - Cycle 1: trigger = 1, ack = 1, `grant_out` and `active_out` = 1, state WAIT_BUSY.
  - Cycle 2: trigger = 0, ack = 0; the wrapper's busy goes high.
  - Cycle 3: state WAIT_DONE.
  - Cycle after busy falls: IDLE, `grant_out` = 0.
  - The earliest next trigger comes one cycle after that.
- `uart_trigger_out` and `req_ack_out` are never high for two consecutive cycles.
- **Watchdog:** when busy stays low, `timeout_err_out` rises at the edge `ACK_TIMEOUT` cycles after the trigger cycle. IDLE is entered on the same edge.
- **Simultaneous requests:** only one ack per transfer; the losers stay pending.
- **Reset mid-transfer:** outputs clear immediately. After reset the block stays idle until `uart_busy_in` is low.

## Test plan
- **Single request:** requester 2 sends 0x1ABCD; the wrapper model asserts busy 1 cycle after trigger and holds it for 30 cycles.
  - Required: exactly one trigger, `uart_data_out` = 0x1ABCD, ack[2] pulse in the trigger cycle, `grant_out` = 0b0100 until busy falls.
- **Round-robin:** all 4 requesters held valid continuously after reset.
  - Required: grant order 0,1,2,3,0,1; exactly one trigger per busy window.
- **Skip idle requesters:** only requesters 1 and 3 are valid, after a last grant of 3.
  - Required: order 1,3,1; requesters 0 and 2 are never acked.
- **Watchdog:** requester 0 valid, busy tied low.
  - Required: `timeout_err_out` rises 8 cycles after the trigger and stays high; the next valid issues a new trigger.
- **Busy blocking:** busy forced high while requester 1 is valid.
  - Required: no trigger until busy drops; the trigger follows 1 cycle later.
- **Reset mid-transfer:** `rst_n_in` pulled low during WAIT_DONE.
  - Required: all outputs 0 within the same cycle, asynchronously. After release, requester 0 wins first, and only once busy is low.

Source files
------------

// File: rtl/uart_word_arbiter.sv
// uart_word_arbiter: round-robin arbiter sharing one 17-bit UART word sender.
// One word per frame; a watchdog flags a sender that never raises busy.
module uart_word_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 17,
   parameter int ACK_TIMEOUT = 8
) (
   input  logic                          clk_in,
   input  logic                          rst_n_in,
   input  logic [NUM_REQ-1:0]            req_valid_in,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
   output logic [NUM_REQ-1:0]            req_ack_out,
   output logic [DATA_WIDTH-1:0]         uart_data_out,
   output logic                          uart_trigger_out,
   input  logic                          uart_busy_in,
   output logic [NUM_REQ-1:0]            grant_out,
   output logic                          active_out,
   output logic                          timeout_err_out
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t                 state;
   state_t                 state_nx;
   logic [PW-1:0]          last_ptr;
   logic [PW-1:0]          last_ptr_nx;
   logic [PW-1:0]          win;
   logic                   found;
   logic [CW-1:0]          wd_cnt;
   logic [CW-1:0]          wd_cnt_nx;
   logic [NUM_REQ-1:0]     grant_nx;
   logic [NUM_REQ-1:0]     ack_nx;
   logic                   trig_nx;
   logic                   err_nx;
   logic [DATA_WIDTH-1:0]  data_nx;
   logic [DATA_WIDTH-1:0]  words [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
      assign words[g] = req_data_in[g*DATA_WIDTH +: DATA_WIDTH];
   end

   // Search starts one past the last winner and wraps modulo NUM_REQ.
   always_comb begin : pick
      int idx;
      idx   = 0;
      win   = last_ptr;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_ptr) + k) % NUM_REQ;
         if (!found && req_valid_in[PW'(idx)]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
   end

   always_comb begin
      state_nx    = state;
      last_ptr_nx = last_ptr;
      wd_cnt_nx   = wd_cnt;
      grant_nx    = grant_out;
      ack_nx      = '0;
      trig_nx     = 1'b0;
      err_nx      = timeout_err_out;
      data_nx     = uart_data_out;
      unique case (state)
         IDLE: begin
            if (found && !uart_busy_in) begin
               state_nx    = WAIT_BUSY;
               data_nx     = words[win];
               grant_nx    = ONE << win;
               ack_nx      = ONE << win;
               trig_nx     = 1'b1;
               last_ptr_nx = win;
               wd_cnt_nx   = '0;
            end
         end
         WAIT_BUSY: begin
            if (uart_busy_in) begin
               state_nx = WAIT_DONE;
            end else if (wd_cnt == CW'(ACK_TIMEOUT - 1)) begin
               // Word is dropped: the requester was already acked.
               wd_cnt_nx = wd_cnt + 1'b1;
               err_nx    = 1'b1;
               grant_nx  = '0;
               state_nx  = IDLE;
            end else begin
               wd_cnt_nx = wd_cnt + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!uart_busy_in) begin
               grant_nx = '0;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state            <= IDLE;
         last_ptr         <= PW'(NUM_REQ - 1);
         wd_cnt           <= '0;
         grant_out        <= '0;
         req_ack_out      <= '0;
         uart_trigger_out <= 1'b0;
         timeout_err_out  <= 1'b0;
         uart_data_out    <= '0;
      end else begin
         state            <= state_nx;
         last_ptr         <= last_ptr_nx;
         wd_cnt           <= wd_cnt_nx;
         grant_out        <= grant_nx;
         req_ack_out      <= ack_nx;
         uart_trigger_out <= trig_nx;
         timeout_err_out  <= err_nx;
         uart_data_out    <= data_nx;
      end
   end

   assign active_out = (state != IDLE);

endmodule

// File: tb/tb_uart_word_arbiter.sv
// Bench for uart_word_arbiter: wrapper busy model plus requester drivers,
// expected grants queued at stimulus time and matched against triggers.
module tb_uart_word_arbiter;

   localparam int N  = 4;
   localparam int W  = 17;
   localparam int TO = 8;
   localparam int BUSY_LEN = 30;

   typedef struct {
      logic [N-1:0] grant;
      logic [N-1:0] ack;
      logic [W-1:0] data;
      logic         prev_busy;
      int           cyc;
   } obs_t;

   typedef struct {
      logic [N-1:0] grant;
      logic [W-1:0] data;
   } exp_t;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   ack;
   logic [W-1:0]   udata;
   logic           trig;
   logic           uart_busy;
   logic [N-1:0]   grant;
   logic           active;
   logic           err;

   logic           model_en;
   logic           force_busy;
   int             busy_cnt = 0;

   logic [W-1:0]   word [N];
   int             rem [N];
   int             ack_cnt [N];
   obs_t           obs_q[$];
   exp_t           exp_q[$];
   int             cyc;
   int             trig_cnt;
   int             err_cyc;
   logic [N-1:0]   err_grant;
   logic           prev_busy;
   int             tests;
   int             fails;

   uart_word_arbiter #(
      .NUM_REQ(N),
      .DATA_WIDTH(W),
      .ACK_TIMEOUT(TO)
   ) dut (
      .clk_in(clk),
      .rst_n_in(rst_n),
      .req_valid_in(valid),
      .req_data_in(req_data),
      .req_ack_out(ack),
      .uart_data_out(udata),
      .uart_trigger_out(trig),
      .uart_busy_in(uart_busy),
      .grant_out(grant),
      .active_out(active),
      .timeout_err_out(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Wrapper model: busy rises the cycle after trigger, lasts BUSY_LEN.
   always @(posedge clk) begin
      if (model_en && trig)
         busy_cnt <= BUSY_LEN;
      else if (busy_cnt > 0)
         busy_cnt <= busy_cnt - 1;
   end

   assign uart_busy = force_busy | (busy_cnt != 0);

   always_comb begin
      req_data = '0;
      for (int i = 0; i < N; i++)
         req_data[i*W +: W] = word[i];
   end

   task automatic step();
      prev_busy = uart_busy;
      @(negedge clk);
      cyc++;
      if (trig === 1'b1) begin
         obs_q.push_back('{grant, ack, udata, prev_busy, cyc});
         trig_cnt++;
      end
      if (err === 1'b1 && err_cyc < 0) begin
         err_cyc   = cyc;
         err_grant = grant;
      end
      for (int i = 0; i < N; i++) begin
         if (ack[i] === 1'b1) begin
            ack_cnt[i]++;
            rem[i]--;
            if (rem[i] <= 0)
               valid[i] = 1'b0;
            else
               word[i] = word[i] + 1'b1;
         end
      end
   endtask

   task automatic do_reset();
      valid      = '0;
      force_busy = 1'b0;
      model_en   = 1'b1;
      for (int i = 0; i < N; i++) begin
         rem[i]  = 0;
         word[i] = '0;
      end
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      obs_q.delete();
      exp_q.delete();
      err_cyc = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      tests++;
      if ({trig, ack, grant, active, err} !== 11'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got %b, required 0",
                  {trig, ack, grant, active, err});
      end
      tests++;
      if (udata !== '0) begin
         fails++;
         $display("FAIL reset_data: got %h, required 0", udata);
      end
      rst_n = 1'b1;
      step();
      step();
      tests++;
      if ({trig, active, grant} !== 6'b0) begin
         fails++;
         $display("FAIL idle_no_req: got %b, required 0",
                  {trig, active, grant});
      end
   endtask

   task automatic test_single();
      int t0;
      int bad;
      obs_t o;
      exp_t e;
      t0  = trig_cnt;
      bad = 0;
      exp_q.push_back('{4'b0100, 17'h1ABCD});
      word[2]  = 17'h1ABCD;
      rem[2]   = 1;
      valid[2] = 1'b1;
      for (int c = 0; c < 50; c++) begin
         step();
         if (uart_busy && grant !== 4'b0100)
            bad++;
      end
      tests++;
      if (trig_cnt - t0 != 1) begin
         fails++;
         $display("FAIL single_trig_count: got %0d, required 1",
                  trig_cnt - t0);
      end
      tests++;
      if (obs_q.size() == 0) begin
         fails++;
         $display("FAIL single_word: no trigger, required 1abcd");
      end else begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         if (o.grant !== e.grant || o.ack !== e.grant
             || o.data !== e.data || o.prev_busy !== 1'b0) begin
            fails++;
            $display("FAIL single_word: got g=%b a=%b d=%h, required g=a=%b d=%h",
                     o.grant, o.ack, o.data, e.grant, e.data);
         end
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL single_grant_hold: %0d bad cycles, required 0", bad);
      end
      tests++;
      if ({grant, active} !== 5'b0) begin
         fails++;
         $display("FAIL single_release: got %b, required 0", {grant, active});
      end
   endtask

   task automatic test_round_robin();
      int ord [6] = '{0, 1, 2, 3, 0, 1};
      int nth [6] = '{0, 0, 0, 0, 1, 1};
      logic [N-1:0] one;
      int pc;
      obs_t o;
      exp_t e;
      do_reset();
      one = 4'b0001;
      for (int k = 0; k < 6; k++)
         exp_q.push_back('{one << ord[k],
                           W'(17'h10000 + ord[k]*256 + nth[k])});
      for (int i = 0; i < N; i++) begin
         word[i] = W'(17'h10000 + i*256);
         rem[i]  = (i < 2) ? 2 : 1;
      end
      valid = 4'b1111;
      for (int c = 0; c < 300 && obs_q.size() < 6; c++)
         step();
      repeat (40) step();
      pc = 0;
      for (int k = 0; k < 6; k++) begin
         tests++;
         if (obs_q.size() == 0) begin
            fails++;
            $display("FAIL rr_order[%0d]: no trigger, required grant %b",
                     k, exp_q[0].grant);
            exp_q.delete();
            break;
         end
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         if (o.grant !== e.grant || o.ack !== e.grant
             || o.data !== e.data || o.prev_busy !== 1'b0) begin
            fails++;
            $display("FAIL rr_order[%0d]: got g=%b a=%b d=%h, required g=a=%b d=%h",
                     k, o.grant, o.ack, o.data, e.grant, e.data);
         end
         if (k > 0) begin
            tests++;
            if (o.cyc - pc != BUSY_LEN + 3) begin
               fails++;
               $display("FAIL rr_gap[%0d]: got %0d, required %0d",
                        k, o.cyc - pc, BUSY_LEN + 3);
            end
         end
         pc = o.cyc;
      end
      tests++;
      if (obs_q.size() != 0) begin
         fails++;
         $display("FAIL rr_extra: got %0d extra triggers, required 0",
                  obs_q.size());
      end
   endtask

   task automatic test_skip();
      int a0;
      int a2;
      int pc;
      obs_t o;
      exp_t e;
      a0 = ack_cnt[0];
      a2 = ack_cnt[2];
      obs_q.delete();
      exp_q.push_back('{4'b1000, 17'h13000});
      word[3]  = 17'h13000;
      rem[3]   = 1;
      valid[3] = 1'b1;
      for (int c = 0; c < 100 && obs_q.size() < 1; c++)
         step();
      exp_q.push_back('{4'b0010, 17'h11100});
      exp_q.push_back('{4'b1000, 17'h13300});
      exp_q.push_back('{4'b0010, 17'h11101});
      word[1] = 17'h11100;
      rem[1]  = 2;
      word[3] = 17'h13300;
      rem[3]  = 1;
      valid   = 4'b1010;
      for (int c = 0; c < 300 && obs_q.size() < 4; c++)
         step();
      repeat (40) step();
      pc = 0;
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (obs_q.size() == 0) begin
            fails++;
            $display("FAIL skip_order[%0d]: no trigger, required grant %b",
                     k, exp_q[0].grant);
            exp_q.delete();
            break;
         end
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         if (o.grant !== e.grant || o.ack !== e.grant || o.data !== e.data) begin
            fails++;
            $display("FAIL skip_order[%0d]: got g=%b d=%h, required g=%b d=%h",
                     k, o.grant, o.data, e.grant, e.data);
         end
         if (k > 1) begin
            tests++;
            if (o.cyc - pc != BUSY_LEN + 3) begin
               fails++;
               $display("FAIL skip_gap[%0d]: got %0d, required %0d",
                        k, o.cyc - pc, BUSY_LEN + 3);
            end
         end
         pc = o.cyc;
      end
      tests++;
      if (ack_cnt[0] != a0 || ack_cnt[2] != a2) begin
         fails++;
         $display("FAIL skip_idle_acked: got %0d/%0d new acks, required 0/0",
                  ack_cnt[0] - a0, ack_cnt[2] - a2);
      end
   endtask

   task automatic test_watchdog();
      obs_t o;
      obs_t o2;
      do_reset();
      model_en = 1'b0;
      for (int c = 0; c < 100 && uart_busy; c++)
         step();
      word[0]  = 17'h10A0A;
      rem[0]   = 2;
      valid[0] = 1'b1;
      for (int c = 0; c < 100 && obs_q.size() < 1; c++)
         step();
      for (int c = 0; c < 30 && err_cyc < 0; c++)
         step();
      repeat (20) step();
      tests++;
      if (obs_q.size() != 2) begin
         fails++;
         $display("FAIL wd_triggers: got %0d, required 2", obs_q.size());
      end else begin
         o  = obs_q.pop_front();
         o2 = obs_q.pop_front();
         if (o.data !== 17'h10A0A || o2.data !== 17'h10A0B
             || o.grant !== 4'b0001 || o2.grant !== 4'b0001) begin
            fails++;
            $display("FAIL wd_triggers: got %h/%h, required 10a0a/10a0b",
                     o.data, o2.data);
         end
         tests++;
         if (err_cyc != o.cyc + TO) begin
            fails++;
            $display("FAIL wd_rise: got cycle +%0d, required +%0d",
                     err_cyc - o.cyc, TO);
         end
         tests++;
         if (o2.cyc != err_cyc + 1) begin
            fails++;
            $display("FAIL wd_retrigger: got cycle +%0d, required +1",
                     o2.cyc - err_cyc);
         end
      end
      tests++;
      if (err_grant !== 4'b0) begin
         fails++;
         $display("FAIL wd_grant: got %b, required 0", err_grant);
      end
      tests++;
      if (err !== 1'b1 || active !== 1'b0) begin
         fails++;
         $display("FAIL wd_sticky: got err=%b act=%b, required 1/0",
                  err, active);
      end
   endtask

   task automatic test_busy_block();
      int t0;
      int drop;
      obs_t o;
      do_reset();
      force_busy = 1'b1;
      word[1]  = 17'h1B00B;
      rem[1]   = 1;
      valid[1] = 1'b1;
      t0 = trig_cnt;
      repeat (10) step();
      tests++;
      if (trig_cnt != t0 || active !== 1'b0) begin
         fails++;
         $display("FAIL busy_block: got %0d triggers, required 0",
                  trig_cnt - t0);
      end
      force_busy = 1'b0;
      drop = cyc;
      for (int c = 0; c < 20 && obs_q.size() < 1; c++)
         step();
      tests++;
      if (obs_q.size() == 0) begin
         fails++;
         $display("FAIL busy_release: no trigger, required at +1");
      end else begin
         o = obs_q.pop_front();
         if (o.cyc != drop + 1 || o.grant !== 4'b0010 || o.data !== 17'h1B00B) begin
            fails++;
            $display("FAIL busy_release: got +%0d g=%b d=%h, required +1 g=0010 d=1b00b",
                     o.cyc - drop, o.grant, o.data);
         end
      end
      repeat (40) step();
   endtask

   task automatic test_reset_mid();
      obs_t o;
      exp_t e;
      do_reset();
      word[2]  = 17'h12222;
      rem[2]   = 1;
      valid[2] = 1'b1;
      for (int c = 0; c < 100 && obs_q.size() < 1; c++)
         step();
      repeat (5) step();
      tests++;
      if (active !== 1'b1 || grant !== 4'b0100) begin
         fails++;
         $display("FAIL mid_active: got act=%b g=%b, required 1/0100",
                  active, grant);
      end
      obs_q.delete();
      force_busy = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({trig, ack, grant, active, err} !== 11'b0 || udata !== '0) begin
         fails++;
         $display("FAIL mid_async_clear: got %b d=%h, required 0",
                  {trig, ack, grant, active, err}, udata);
      end
      word[0]  = 17'h10001;
      rem[0]   = 1;
      word[3]  = 17'h13003;
      rem[3]   = 1;
      valid    = 4'b1001;
      step();
      rst_n = 1'b1;
      repeat (5) step();
      tests++;
      if (obs_q.size() != 0) begin
         fails++;
         $display("FAIL mid_busy_hold: got %0d triggers, required 0",
                  obs_q.size());
      end
      force_busy = 1'b0;
      exp_q.push_back('{4'b0001, 17'h10001});
      exp_q.push_back('{4'b1000, 17'h13003});
      for (int c = 0; c < 200 && obs_q.size() < 2; c++)
         step();
      for (int k = 0; k < 2; k++) begin
         tests++;
         if (obs_q.size() == 0) begin
            fails++;
            $display("FAIL mid_order[%0d]: no trigger, required grant %b",
                     k, exp_q[0].grant);
            exp_q.delete();
            break;
         end
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         if (o.grant !== e.grant || o.data !== e.data || o.prev_busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_order[%0d]: got g=%b d=%h pb=%b, required g=%b d=%h pb=0",
                     k, o.grant, o.data, o.prev_busy, e.grant, e.data);
         end
      end
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      cyc        = 0;
      trig_cnt   = 0;
      err_cyc    = -1;
      err_grant  = '0;
      prev_busy  = 1'b0;
      rst_n      = 1'b0;
      valid      = '0;
      model_en   = 1'b1;
      force_busy = 1'b0;
      for (int i = 0; i < N; i++) begin
         word[i]    = '0;
         rem[i]     = 0;
         ack_cnt[i] = 0;
      end
      test_reset();
      test_single();
      test_round_robin();
      test_skip();
      test_watchdog();
      test_busy_block();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
